// File: rtl/wave_capture_if.sv
// -----------------------------------------------------------------------------
// wave_capture_if
// Bundles the sample stream input, the display idle flag and the sample-RAM
// write port between the audio side and the wave capture block.
//   new_sample_ready  : one-cycle strobe, new_sample_in valid this cycle
//   new_sample_in     : signed audio sample, SAMPLE_WIDTH bits
//   wave_display_idle : display is outside the wave region; buffers may swap
//   write_address     : RAM write address {~read_index, sample_count}
//   write_enable      : RAM write strobe
//   write_sample      : display-scaled sample, 0 = top of wave area
//   read_index        : buffer half the display reads
//   armed             : capture is waiting for a trigger
// Modports: master drives the stream/idle inputs and observes the outputs;
//           slave is the capture block itself.
// -----------------------------------------------------------------------------
interface wave_capture_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_BITS    = 8
);
    logic                    new_sample_ready;
    logic [SAMPLE_WIDTH-1:0] new_sample_in;
    logic                    wave_display_idle;
    logic [ADDR_BITS:0]      write_address;
    logic                    write_enable;
    logic [7:0]              write_sample;
    logic                    read_index;
    logic                    armed;

    modport master (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index,
        input  armed
    );

    modport slave (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index,
        output armed
    );
endinterface

// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
// Triggers on a rising zero crossing of the audio sample stream and writes
// 2^ADDR_BITS display-scaled samples into the RAM half the display is not
// reading. The halves are swapped only while the display is idle, so the
// display always shows one complete, stable capture.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset (0 = in reset)
//   bus   : wave_capture_if.slave (sample stream in, RAM write port out)
// -----------------------------------------------------------------------------
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_BITS    = 8
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_read_index;
    logic                 w_read_index_next;
    logic [ADDR_BITS-1:0] r_sample_count;
    logic [ADDR_BITS-1:0] w_sample_count_next;
    // Only the sign of the previous sample takes part in trigger detection,
    // so that is all that is kept of it.
    logic                 r_prev_sign;
    logic                 r_write_enable;
    logic                 w_write_enable_next;
    logic [ADDR_BITS:0]   r_write_address;
    logic [ADDR_BITS:0]   w_write_address_next;
    logic [7:0]           r_write_sample;
    logic [7:0]           w_write_sample_next;
    logic                 r_armed;
    logic                 w_armed_next;

    logic [7:0]           w_top_byte;
    logic [7:0]           w_offset;
    logic [7:0]           w_scaled;
    logic                 w_trigger;
    logic                 w_last_write;

    // Display scaling: top byte to offset binary, then invert so the most
    // positive sample lands on row 0 (top of the wave area).
    assign w_top_byte = bus.new_sample_in[SAMPLE_WIDTH-1 -: 8];
    assign w_offset   = {~w_top_byte[7], w_top_byte[6:0]};
    assign w_scaled   = 8'd255 - w_offset;

    // Rising zero crossing: previous sample negative, current non-negative.
    assign w_trigger    = bus.new_sample_ready && r_prev_sign
                          && !bus.new_sample_in[SAMPLE_WIDTH-1];
    assign w_last_write = (r_sample_count == {ADDR_BITS{1'b1}});

    always_comb begin
        w_state_next         = r_state;
        w_read_index_next    = r_read_index;
        w_sample_count_next  = r_sample_count;
        w_write_enable_next  = 1'b0;
        w_write_address_next = r_write_address;
        w_write_sample_next  = r_write_sample;

        case (r_state)
            ST_ARMED: begin
                if (w_trigger) begin
                    w_write_enable_next  = 1'b1;
                    w_write_address_next = {~r_read_index, {ADDR_BITS{1'b0}}};
                    w_write_sample_next  = w_scaled;
                    w_sample_count_next  = ADDR_BITS'(1);
                    w_state_next         = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    w_write_enable_next  = 1'b1;
                    w_write_address_next = {~r_read_index, r_sample_count};
                    w_write_sample_next  = w_scaled;
                    // Natural wrap of the counter brings it back to 0.
                    w_sample_count_next  = r_sample_count + ADDR_BITS'(1);
                    if (w_last_write) begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A sample arriving on the swap cycle is not evaluated for
                // a trigger; it only refreshes the previous-sign register.
                if (bus.wave_display_idle) begin
                    w_read_index_next = ~r_read_index;
                    w_state_next      = ST_ARMED;
                end
            end
            default: begin
                w_state_next = ST_ARMED;
            end
        endcase

        w_armed_next = (w_state_next == ST_ARMED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_ARMED;
            r_read_index    <= 1'b0;
            r_sample_count  <= '0;
            r_prev_sign     <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_sample  <= '0;
            r_armed         <= 1'b1;
        end else begin
            r_state         <= w_state_next;
            r_read_index    <= w_read_index_next;
            r_sample_count  <= w_sample_count_next;
            if (bus.new_sample_ready) begin
                r_prev_sign <= bus.new_sample_in[SAMPLE_WIDTH-1];
            end
            r_write_enable  <= w_write_enable_next;
            r_write_address <= w_write_address_next;
            r_write_sample  <= w_write_sample_next;
            r_armed         <= w_armed_next;
        end
    end

    assign bus.write_address = r_write_address;
    assign bus.write_enable  = r_write_enable;
    assign bus.write_sample  = r_write_sample;
    assign bus.read_index    = r_read_index;
    assign bus.armed         = r_armed;

endmodule

// File: tb/tb_wave_capture.sv
// -----------------------------------------------------------------------------
// tb_wave_capture
// Scoreboard bench: stimulus pushes each expected RAM write {address, sample}
// into a queue; a monitor pops and compares on every write_enable. Status
// outputs (armed, read_index, reset values) are checked directly.
// -----------------------------------------------------------------------------
module tb_wave_capture;

    logic clk;
    logic rst_n;

    wave_capture_if #(.SAMPLE_WIDTH(16), .ADDR_BITS(8)) bus ();

    wave_capture #(.SAMPLE_WIDTH(16), .ADDR_BITS(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    logic [16:0] exp_q[$];

    // Independent scaling model: 127 minus the signed top byte.
    function automatic logic [7:0] exp_scale(input logic [15:0] x);
        int v;
        v = 127 - int'($signed(x[15:8]));
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0h sample=%0d expected=none",
                         bus.write_address, bus.write_sample);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({bus.write_address, bus.write_sample} !== e) begin
                    bad++;
                    $display("FAIL write: addr=%0h sample=%0d expected addr=%0h sample=%0d",
                             bus.write_address, bus.write_sample, e[16:8], e[7:0]);
                end else begin
                    $display("wr   addr=%0h sample=%0d", bus.write_address, bus.write_sample);
                end
            end
        end
    end

    task automatic strobe(input logic [15:0] x);
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b1;
        bus.new_sample_in    = x;
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic push(input logic [8:0] addr, input logic [7:0] smp);
        exp_q.push_back({addr, smp});
    endtask

    // Remaining 255 samples of a capture into half 'half'; two full-scale
    // values are placed mid-capture with hand-computed results.
    task automatic capture_rest(input logic half);
        for (int i = 1; i < 256; i++) begin
            logic [15:0] s;
            logic [7:0]  ib;
            ib = 8'(i);
            if (i == 10) begin
                s = 16'h7FFF;
                push({half, ib}, 8'd0);
            end else if (i == 11) begin
                s = 16'h8000;
                push({half, ib}, 8'd255);
            end else begin
                s = 16'(i * 256 + 16'h0034);
                push({half, ib}, exp_scale(s));
            end
            strobe(s);
        end
    endtask

    task automatic pulse_idle();
        @(posedge clk);
        #1;
        bus.wave_display_idle = 1'b1;
        @(posedge clk);
        #1;
        bus.wave_display_idle = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_write_enable", 32'(bus.write_enable), 32'd0);
        check("rst_write_address", 32'(bus.write_address), 32'd0);
        check("rst_write_sample", 32'(bus.write_sample), 32'd0);
        check("rst_read_index", 32'(bus.read_index), 32'd0);
        check("rst_armed", 32'(bus.armed), 32'd1);
        rst_n = 1'b1;

        // Positive samples with no negative before them: no trigger.
        strobe(16'h1000);
        strobe(16'h2000);
        repeat (2) @(posedge clk);
        #1;
        check("armed_no_trigger", 32'(bus.armed), 32'd1);

        // Rising zero crossing.
        strobe(16'hF000);
        push(9'h100, 8'd126);
        strobe(16'h0100);
        check("armed_after_trigger", 32'(bus.armed), 32'd0);
        capture_rest(1'b1);

        // WAIT: strobes, including a would-be trigger, produce no writes.
        strobe(16'hF000);
        strobe(16'h0100);
        repeat (1000) @(posedge clk);
        #1;
        check("wait_read_index_hold", 32'(bus.read_index), 32'd0);
        check("wait_not_armed", 32'(bus.armed), 32'd0);
        pulse_idle();
        check("swap_read_index", 32'(bus.read_index), 32'd1);
        check("swap_armed", 32'(bus.armed), 32'd1);

        // Second capture lands in the lower half.
        strobe(16'h8000);
        push(9'h000, 8'd125);
        strobe(16'h0200);
        capture_rest(1'b0);
        repeat (5) @(posedge clk);
        pulse_idle();
        check("swap_back_read_index", 32'(bus.read_index), 32'd0);

        // Reset mid-capture after 100 writes.
        strobe(16'hC000);
        push(9'h100, 8'd126);
        strobe(16'h0100);
        for (int i = 1; i < 100; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            push({1'b1, ib}, exp_scale(16'h0500));
            strobe(16'h0500);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_write_address", 32'(bus.write_address), 32'd0);
        check("async_rst_armed", 32'(bus.armed), 32'd1);
        check("async_rst_read_index", 32'(bus.read_index), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh trigger after reset starts at the upper half again.
        strobe(16'hF000);
        push(9'h100, 8'd126);
        strobe(16'h0100);
        check("post_rst_armed", 32'(bus.armed), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
